// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: 1 ms row strobe, single-key debounce on press and
// release, and entry of accepted hex digits into a 16-bit shift word.
module hex_keypad_scanner #(
  parameter int Fclk   = 50000,
  parameter int F1kHz  = 1,
  parameter int DEB_MS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic [15:0] dat,
  output logic [1:0]  ptr_P,
  output logic [3:0]  key_code,
  output logic        key_vld,
  output logic        ce1ms,
  output logic [1:0]  state_dbg
);

  localparam int TDIV = Fclk / F1kHz;
  localparam int CW   = $clog2(TDIV + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cb_1ms;
  logic          ce;
  logic [3:0]    col_m, col_s;
  logic [1:0]    ridx, cidx, cidx_l;
  logic          single_low;
  logic [3:0]    deb_cnt, rel_cnt;
  logic [3:0]    held_pat;
  logic [3:0]    code;

  assign ce        = (cb_1ms == CW'(TDIV));
  assign row       = ~(4'b0001 << ridx);
  assign held_pat  = ~(4'b0001 << cidx_l);
  assign code      = {ridx, cidx_l};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb_1ms <= '0;
      ce1ms  <= 1'b0;
    end else begin
      cb_1ms <= ce ? CW'(1) : cb_1ms + CW'(1);
      ce1ms  <= ce;
    end
  end

  // col is asynchronous to clk; idle (pulled-up) value is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  always_comb begin
    single_low = 1'b1;
    cidx       = 2'd0;
    case (col_s)
      4'b1110: cidx = 2'd0;
      4'b1101: cidx = 2'd1;
      4'b1011: cidx = 2'd2;
      4'b0111: cidx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  // Row index stays frozen outside SCAN, so the latched row is the key's row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SCAN;
      ridx     <= 2'd0;
      cidx_l   <= 2'd0;
      deb_cnt  <= 4'd0;
      rel_cnt  <= 4'd0;
      dat      <= 16'h0000;
      ptr_P    <= 2'd0;
      key_code <= 4'd0;
      key_vld  <= 1'b0;
    end else begin
      key_vld <= 1'b0;
      if (ce) begin
        case (state)
          SCAN: begin
            if (single_low) begin
              cidx_l  <= cidx;
              deb_cnt <= 4'd1;
              state   <= DEBOUNCE;
            end else begin
              ridx <= ridx + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (col_s == held_pat) begin
              deb_cnt <= deb_cnt + 4'd1;
              if (deb_cnt == 4'(DEB_MS - 1)) begin
                key_code <= code;
                key_vld  <= 1'b1;
                dat      <= {dat[11:0], code};
                ptr_P    <= ptr_P + 2'd1;
                rel_cnt  <= 4'd0;
                state    <= HELD;
              end
            end else begin
              ridx  <= ridx + 2'd1;
              state <= SCAN;
            end
          end
          HELD: begin
            if (col_s == 4'hF) begin
              rel_cnt <= rel_cnt + 4'd1;
              if (rel_cnt == 4'(DEB_MS - 1)) begin
                ridx  <= ridx + 2'd1;
                state <= SCAN;
              end
            end else begin
              rel_cnt <= 4'd0;
            end
          end
          default: state <= SCAN;
        endcase
      end
      // clr overrides a coincident acceptance for the word and pointer only.
      if (clr) begin
        dat   <= 16'h0000;
        ptr_P <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: a physical keypad model drives col from row,
// and an event-level model of the entered word checks outputs every cycle.
module tb_hex_keypad_scanner;

  localparam int P   = 10;
  localparam int DEB = 4;

  logic        clk, rst_n, clr;
  logic [3:0]  col, row, key_code;
  logic [15:0] dat;
  logic [1:0]  ptr_P, state_dbg;
  logic        key_vld, ce1ms;

  hex_keypad_scanner #(.Fclk(P), .F1kHz(1), .DEB_MS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .clr(clr), .row(row), .dat(dat),
    .ptr_P(ptr_P), .key_code(key_code), .key_vld(key_vld), .ce1ms(ce1ms),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its column to its row; force overrides.
  logic       key_dn, force_en;
  int         key_r, key_c;
  logic [3:0] force_col;
  always_comb begin
    col = 4'hF;
    if (force_en) col = force_col;
    else if (key_dn && row[key_r] == 1'b0) col[key_c] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: dat/ptr follow accepted codes and clr; ce1ms period from cycle count.
  logic [15:0] m_dat = 16'h0;
  int          m_ptr = 0;
  int          cyc = 0;
  int          vld_cnt = 0;
  logic [3:0]  prev_row = 4'hE;
  logic [3:0]  e;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cyc = 0; m_dat = 16'h0; m_ptr = 0;
      exp_q.delete();
      chk("rst_row", row, 4'hE);
      chk("rst_dat", dat, 0);
      chk("rst_ptr", ptr_P, 0);
      chk("rst_key_code", key_code, 0);
      chk("rst_key_vld", key_vld, 0);
      chk("rst_ce1ms", ce1ms, 0);
    end else begin
      cyc++;
      if (key_vld) begin
        vld_cnt++;
        if (exp_q.size() == 0) chk("unexpected_key_vld", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("key_code", key_code, e);
          m_dat = {m_dat[11:0], e};
          m_ptr = (m_ptr + 1) % 4;
        end
      end
      if (clr) begin
        m_dat = 16'h0; m_ptr = 0;
      end
      chk("dat", dat, m_dat);
      chk("ptr_P", ptr_P, m_ptr);
      chk("ce1ms", ce1ms, (cyc >= P + 1) && ((cyc - 1) % P == 0));
      chk("row_onehot", (row == 4'hE || row == 4'hD || row == 4'hB || row == 4'h7), 1);
      if (row != prev_row) chk("row_step_on_tick", ce1ms, 1);
    end
    prev_row = row;
  end

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!ce1ms && n < 4 * P) begin
      @(negedge clk); n++;
    end
    if (!ce1ms) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_debounce();
    int n = 0;
    while (state_dbg != 2'd1 && n < 8 * P) begin
      @(negedge clk); n++;
    end
    chk("reach_debounce", state_dbg, 2'd1);
  endtask

  task automatic press_key(input int code);
    key_r = code / 4; key_c = code % 4; key_dn = 1'b1;
    exp_q.push_back(4'(code));
    repeat (10 * P) @(negedge clk);
    key_dn = 1'b0;
    repeat (6 * P) @(negedge clk);
    chk("scan_resumed", state_dbg, 2'd0);
    chk("key_consumed", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v0, changes;
    logic [3:0] r0;
    rst_n = 1'b0; clr = 1'b0; key_dn = 1'b0; force_en = 1'b0;
    force_col = 4'hF; key_r = 0; key_c = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: first tick after P+1 edges, rows step 1101,1011,0111,1110.
    n = 0;
    do begin @(negedge clk); n++; end while (!ce1ms && n < 100);
    chk("first_ce1ms_cycle", n, P + 1);
    chk("idle_row1", row, 4'hD);
    wait_tick(); chk("idle_row2", row, 4'hB);
    wait_tick(); chk("idle_row3", row, 4'h7);
    wait_tick(); chk("idle_row0", row, 4'hE);
    chk("idle_no_vld", vld_cnt, 0);

    // Key 9 (row 2, col 1).
    press_key(9);
    chk("key9_vld_count", vld_cnt, 1);
    chk("key9_code", key_code, 4'h9);
    chk("key9_dat", dat, 16'h0009);
    chk("key9_ptr", ptr_P, 1);

    // Bounce: col[0] low for two ticks only.
    wait_tick();
    force_en = 1'b1; force_col = 4'b1110;
    repeat (P + 3) @(negedge clk);
    chk("bounce_entered_debounce", state_dbg, 2'd1);
    repeat (P - 3) @(negedge clk);
    force_en = 1'b0;
    repeat (2 * P) @(negedge clk);
    chk("bounce_back_to_scan", state_dbg, 2'd0);
    chk("bounce_no_vld", vld_cnt, 1);
    chk("bounce_dat", dat, 16'h0009);

    // clr, then 1,2,3,A and a wrapping 5th key.
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr_dat", dat, 16'h0);
    chk("clr_ptr", ptr_P, 0);
    press_key(1); press_key(2); press_key(3); press_key(10);
    chk("seq_dat", dat, 16'h123A);
    chk("seq_ptr_wrap", ptr_P, 0);
    press_key(5);
    chk("seq5_dat", dat, 16'h23A5);
    chk("seq5_ptr", ptr_P, 1);

    // Two columns low: never accepted, scanning continues every tick.
    v0 = vld_cnt;
    force_en = 1'b1; force_col = 4'b1100;
    changes = 0; r0 = row;
    repeat (20 * P) begin
      @(negedge clk);
      if (row != r0) changes++;
      r0 = row;
    end
    force_en = 1'b0;
    chk("multi_row_steps", changes, 20);
    chk("multi_no_vld", vld_cnt, v0);
    chk("multi_state", state_dbg, 2'd0);
    repeat (2 * P) @(negedge clk);

    // clr on the acceptance edge of key C (code 12).
    key_r = 3; key_c = 0; key_dn = 1'b1;
    exp_q.push_back(4'd12);
    v0 = vld_cnt;
    wait_debounce();
    repeat (3 * P - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clracc_key_vld", key_vld, 1);
    chk("clracc_key_code", key_code, 4'hC);
    chk("clracc_dat", dat, 16'h0);
    chk("clracc_ptr", ptr_P, 0);
    key_dn = 1'b0;
    repeat (6 * P) @(negedge clk);
    chk("clracc_vld_count", vld_cnt, v0 + 1);

    press_key(7);
    chk("key7_dat", dat, 16'h0007);

    // Asynchronous reset in the middle of a debounce.
    v0 = vld_cnt;
    key_r = 1; key_c = 2; key_dn = 1'b1;
    wait_debounce();
    repeat (P) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_row", row, 4'hE);
    chk("arst_dat", dat, 16'h0);
    chk("arst_ptr", ptr_P, 0);
    chk("arst_key_code", key_code, 0);
    chk("arst_state", state_dbg, 2'd0);
    key_dn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 * P) @(negedge clk);
    chk("arst_no_vld", vld_cnt, v0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
